bs_add_sched: RTL and testbench
===============================

BS_ADD_SCHED -- requirements
Module: bs_add_sched

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  SHALL indicate that requester 0 / 1 holds an add request.
REQ-005 req0_ready / req1_ready  output  1 each  SHALL indicate request acceptance; a transfer happens when valid & ready in the same cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  SHALL carry the operands, sampled only on transfer.
REQ-007 bs_a, bs_b  output  1 each  SHALL carry the serialized operand bits to the shared bit-serial adder, LSB first.
REQ-008 bs_isync  output  1  SHALL be high only on the cycle that presents operand bit 0; it clears the adder carry.
REQ-009 bs_q  input  1  SHALL be the registered sum bit returned by the adder, one cycle after its operand bits.
REQ-010 bs_osync  input  1  SHALL be the adder's registered copy of bs_isync, marking sum bit 0 on bs_q.
REQ-011 rsp_valid  output  1 / rsp_ready  input  1  SHALL form the result handshake.
REQ-012 rsp_data  output  WIDTH  SHALL carry the sum (a + b) mod 2^WIDTH.
REQ-013 rsp_id  output  1  SHALL identify the requester (0 or 1) that owns rsp_data.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DRAIN, RESP; reset state IDLE.
REQ-015 In IDLE, the block SHALL assert ready to exactly one requester, the grant winner, and to none when neither is valid.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, the grant goes to the requester not served last; if one is valid, the grant goes to that one; after reset the last-served pointer is 1, so requester 0 wins the first tie.
REQ-017 The last-served pointer SHALL update only on an accepted transfer.
REQ-018 On a transfer in cycle T, the block SHALL latch the operands and the id, and enter SHIFT at T+1.
REQ-019 SHIFT SHALL last exactly WIDTH cycles (T+1..T+WIDTH) and present operand bit i on bs_a/bs_b at cycle T+1+i.
REQ-020 bs_isync SHALL be 1 at T+1 only.
REQ-021 Outside SHIFT, bs_a, bs_b and bs_isync SHALL be 0.
REQ-022 Result capture SHALL start on the cycle bs_osync=1 (T+2); the block SHALL shift bs_q in as result bits 0..WIDTH-1 over cycles T+2..T+WIDTH+1.
REQ-023 The carry out of bit WIDTH-1 SHALL be discarded.
REQ-024 DRAIN SHALL last one cycle (T+WIDTH+1) to capture the final sum bit.
REQ-025 The FSM SHALL then enter RESP at T+WIDTH+2 with rsp_valid=1.
REQ-026 In RESP, rsp_valid, rsp_data and rsp_id SHALL be held stable until rsp_ready=1; the state then returns to IDLE on the next cycle.
REQ-027 No request SHALL be accepted outside IDLE, so minimum spacing between accepts is WIDTH+3 cycles.
REQ-028 Requests arriving during SHIFT/DRAIN/RESP SHALL wait with ready=0 and SHALL NOT be dropped.
REQ-029 A bit counter SHALL count 0..WIDTH-1 in SHIFT and SHALL NOT wrap into a second word.
REQ-030 If bs_osync is not seen at T+2, capture SHALL still proceed on the cycle count (osync is checked by assertion, not used for recovery).
REQ-031 rsp_data SHALL be a registered output; no combinational path SHALL exist from req* inputs to rsp* outputs.

Reset
REQ-032 While reset=1, the block SHALL drive req0_ready=0, req1_ready=0, bs_a=0, bs_b=0, bs_isync=0, rsp_valid=0, rsp_data=0, rsp_id=0.
REQ-033 While reset=1, the state SHALL be IDLE, the counter 0 and the RR pointer 1.
REQ-034 Reset asserted mid-operation (SHIFT, DRAIN or RESP) SHALL abandon the operation with no response issued.
REQ-035 The first ready SHALL appear in the cycle after reset deasserts.

Verification (WIDTH=16, bench includes a behavioural 1-cycle bit-serial adder)
REQ-036 Single request: req0 a=0x1234 b=0x0FED accepted at T -> rsp_valid at T+18, rsp_data=0x2221, rsp_id=0.
REQ-037 Overflow: req1 a=0xFFFF b=0x0001 -> rsp_data=0x0000, rsp_id=1, and the next op a=0x0001 b=0x0001 -> 0x0002 (no carry leak across isync).
REQ-038 Contention: both valid continuously from reset -> grants alternate 0,1,0,1; each accept is spaced exactly 19 cycles with rsp_ready tied 1.
REQ-039 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_data and rsp_id stable; req*_ready=0 throughout; accept occurs the cycle after the rsp handshake's IDLE entry.
REQ-040 Mid-op reset: reset pulsed at T+8 -> all outputs 0 the following cycle, no rsp_valid, and the pending req0 is re-granted after reset deasserts.
REQ-041 Waveform check: bs_isync high exactly one cycle per operation, bs_a over 16 cycles equals operand a LSB first, and bs_a, bs_b = 0 in IDLE/DRAIN/RESP.

Source files
------------

// File: rtl/bs_add_sched_if.sv
// Bundle of requester, bit-serial adder and result handshake signals for bs_add_sched.
// master = surrounding environment (requesters, adder, result sink); slave = the scheduler.
interface bs_add_sched_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             bs_a;
  logic             bs_b;
  logic             bs_isync;
  logic             bs_q;
  logic             bs_osync;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output bs_q, bs_osync, rsp_ready,
    input  req0_ready, req1_ready, bs_a, bs_b, bs_isync,
    input  rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  bs_q, bs_osync, rsp_ready,
    output req0_ready, req1_ready, bs_a, bs_b, bs_isync,
    output rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/bs_add_sched.sv
// Two-requester round-robin scheduler feeding a shared 1-cycle bit-serial adder,
// serializing operands LSB first and reassembling the registered sum bits.
module bs_add_sched #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  bs_add_sched_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, RESP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             id;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             a_bit;
  logic             b_bit;
  logic             isync;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  logic             grant0;
  logic             grant1;
  logic             take0;
  logic             take1;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last);
    take0  = (state == IDLE) && !reset && grant0;
    take1  = (state == IDLE) && !reset && grant1;
    sel_a  = take1 ? bus.req1_a : bus.req0_a;
    sel_b  = take1 ? bus.req1_b : bus.req0_b;
  end

  assign bus.req0_ready = take0;
  assign bus.req1_ready = take1;
  assign bus.bs_a       = a_bit;
  assign bus.bs_b       = b_bit;
  assign bus.bs_isync   = isync;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_id     = rsp_id;

  // rsp_data doubles as the result shift register; it is only meaningful while rsp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      id        <= 1'b0;
      sh_a      <= '0;
      sh_b      <= '0;
      a_bit     <= 1'b0;
      b_bit     <= 1'b0;
      isync     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take0 || take1) begin
            a_bit <= sel_a[0];
            b_bit <= sel_b[0];
            sh_a  <= sel_a >> 1;
            sh_b  <= sel_b >> 1;
            isync <= 1'b1;
            cnt   <= '0;
            id    <= take1;
            last  <= take1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          isync <= 1'b0;
          // Sum bit i returns one cycle after operand bit i, so capture lags by one.
          if (cnt != '0) begin
            rsp_data <= {bus.bs_q, rsp_data[WIDTH-1:1]};
          end
          if (cnt == CW'(WIDTH - 1)) begin
            a_bit <= 1'b0;
            b_bit <= 1'b0;
            state <= DRAIN;
          end else begin
            a_bit <= sh_a[0];
            b_bit <= sh_b[0];
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          rsp_data  <= {bus.bs_q, rsp_data[WIDTH-1:1]};
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_osync_aligned: assert property (@(posedge clk) disable iff (reset)
    (state == SHIFT && cnt == CW'(1)) |-> bus.bs_osync);
endmodule

// File: tb/tb_bs_add_sched.sv
// Scoreboard bench for bs_add_sched with a behavioural 1-cycle bit-serial adder.
module tb_bs_add_sched;
  localparam int unsigned WIDTH = 16;
  localparam int LAT = WIDTH + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  bs_add_sched_if #(.WIDTH(WIDTH)) bus ();
  bs_add_sched #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: registered sum bit, carry cleared by isync.
  logic carry;
  always @(posedge clk) begin
    if (reset) begin
      bus.bs_q     <= 1'b0;
      bus.bs_osync <= 1'b0;
      carry        <= 1'b0;
    end else begin
      bus.bs_q     <= bus.bs_a ^ bus.bs_b ^ (carry & ~bus.bs_isync);
      carry        <= (bus.bs_a & bus.bs_b) | ((bus.bs_a ^ bus.bs_b) & carry & ~bus.bs_isync);
      bus.bs_osync <= bus.bs_isync;
    end
  end

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  // Expected sums are pushed on each accepted request and popped on each result handshake.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        mon_e.id = 1'b0; mon_e.data = bus.req0_a + bus.req0_b; mon_e.cyc = cyc;
        sb.push_back(mon_e);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        mon_e.id = 1'b1; mon_e.data = bus.req1_a + bus.req1_b; mon_e.cyc = cyc;
        sb.push_back(mon_e);
      end
      if (bus.rsp_valid && !prev_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required no response", cyc);
        end else if (cyc - sb[0].cyc != LAT) begin
          n_fail++;
          $display("FAIL rsp_latency: got %0d cycles, required %0d", cyc - sb[0].cyc, LAT);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        n_checks++;
        if ({bus.rsp_id, bus.rsp_data} !== {mon_e.id, mon_e.data}) begin
          n_fail++;
          $display("FAIL rsp_data: got id=%0d data=%h, required id=%0d data=%h",
                   bus.rsp_id, bus.rsp_data, mon_e.id, mon_e.data);
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  task automatic wait_accept(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (which ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req0_a = 16'h1234; bus.req0_b = 16'h0FED;
    bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0001;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.bs_a, bus.bs_b, bus.bs_isync,
           bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got r0=%b r1=%b a=%b b=%b is=%b v=%b d=%h id=%b, required all 0",
                 bus.req0_ready, bus.req1_ready, bus.bs_a, bus.bs_b, bus.bs_isync,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
    end
  endtask

  task automatic test_contention();
    int ts[4];
    logic [3:0] ids;
    int k = 0;
    int t_rel;
    bit dual = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    t_rel = cyc;
    for (int n = 0; n < 200 && k < 4; n++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) dual = 1'b1;
      if (bus.req0_ready || bus.req1_ready) begin
        ids[k] = bus.req1_ready;
        ts[k]  = cyc;
        k++;
      end
    end
    @(posedge clk); #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n_checks++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL contention_accepts: got %0d accepts, required 4", k);
    end else begin
      n_checks++;
      if (ts[0] != t_rel) begin
        n_fail++;
        $display("FAIL first_ready: got cycle %0d, required %0d", ts[0], t_rel);
      end
      n_checks++;
      if (ids !== 4'b1010) begin
        n_fail++;
        $display("FAIL grant_order: got %b (bit0 first), required 1010", ids);
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (ts[i] - ts[i-1] != WIDTH + 3) begin
          n_fail++;
          $display("FAIL accept_spacing%0d: got %0d, required %0d", i, ts[i] - ts[i-1], WIDTH + 3);
        end
      end
    end
    n_checks++;
    if (dual) begin
      n_fail++;
      $display("FAIL single_grant: got both ready at once, required one");
    end
    repeat (24) @(negedge clk);
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] ca = '0;
    logic [WIDTH-1:0] cb = '0;
    logic [WIDTH-1:0] is_seen = '0;
    logic idle_bits;
    bit ok;
    @(posedge clk); #1;
    bus.req0_a = 16'h1234; bus.req0_b = 16'h0FED; bus.req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    idle_bits = bus.bs_a | bus.bs_b | bus.bs_isync;
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      if (i < WIDTH) begin
        ca[i] = bus.bs_a; cb[i] = bus.bs_b; is_seen[i] = bus.bs_isync;
      end else begin
        idle_bits = idle_bits | bus.bs_a | bus.bs_b | bus.bs_isync;
      end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: got no accept, required one"); end
    n_checks++;
    if (ca !== 16'h1234) begin n_fail++; $display("FAIL wave_bs_a: got %h, required 1234", ca); end
    n_checks++;
    if (cb !== 16'h0FED) begin n_fail++; $display("FAIL wave_bs_b: got %h, required 0fed", cb); end
    n_checks++;
    if (is_seen !== 16'h0001) begin n_fail++; $display("FAIL wave_isync: got %h, required 0001", is_seen); end
    n_checks++;
    if (idle_bits !== 1'b0) begin n_fail++; $display("FAIL wave_idle: got %b, required 0", idle_bits); end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 16'h2221}) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b id=%b d=%h, required v=1 id=0 d=2221",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    @(posedge clk); #1;
    bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0001; bus.req1_valid = 1'b1;
    wait_accept(1'b1, ok);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    n_checks++;
    if (!ok || {bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL overflow_rsp: got ok=%b v=%b id=%b d=%h, required v=1 id=1 d=0000",
               ok, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    @(posedge clk); #1;
    bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    n_checks++;
    if (!ok || {bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 16'h0002}) begin
      n_fail++;
      $display("FAIL carry_clear_rsp: got ok=%b v=%b id=%b d=%h, required v=1 id=0 d=0002",
               ok, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit found = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req0_a = 16'h00FF; bus.req0_b = 16'h0F01; bus.req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_a = 16'h7000; bus.req1_b = 16'h1000; bus.req1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!ok || !found) begin
      n_fail++;
      $display("FAIL bp_rsp_seen: got accept=%b valid=%b, required both 1", ok, found);
    end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req0_ready, bus.req1_ready}
          !== {1'b1, 1'b0, 16'h1000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b id=%b d=%h r0=%b r1=%b, required v=1 id=0 d=1000 r0=0 r1=0",
                 j, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req0_ready, bus.req1_ready);
      end
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_handshake: got v=%b r1=%b, required v=1 r1=0", bus.rsp_valid, bus.req1_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_pending_accept: got v=%b r1=%b, required v=0 r1=1", bus.rsp_valid, bus.req1_ready);
    end
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic test_midop_reset();
    bit ok;
    @(posedge clk); #1;
    bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    @(posedge clk); #1;
    bus.req0_a = 16'h0003; bus.req0_b = 16'h0004;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!ok || bus.req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_ready: got accept=%b r0=%b, required accept=1 r0=0", ok, bus.req0_ready);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.bs_a, bus.bs_b, bus.bs_isync, bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== '0) begin
      n_fail++;
      $display("FAIL midop_outputs: got a=%b b=%b is=%b v=%b d=%h id=%b, required all 0",
               bus.bs_a, bus.bs_b, bus.bs_isync, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_regrant: got r0=%b, required 1", bus.req0_ready);
    end
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_overflow();
    test_backpressure();
    test_midop_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
